jelly_cpu_dbus_ctl: RTL

Data-bus access controller for the MIPS-like CPU core.
- Accepts one load/store request at a time from the MEM stage.
- Uses the memory access encoder to build the byte-select and write-data lanes.
- Runs a single-beat Wishbone-classic transaction and stalls the pipeline until it completes.
- Aligns, extends or merges (LWL/LWR) the read data before returning it to writeback.

---
 rtl/jelly_cpu_pkg.sv | 45 ++++
 rtl/jelly_cpu_memenc.sv | 74 +++++++
 rtl/jelly_cpu_dbus_ctl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/jelly_cpu_pkg.sv
// rtl/jelly_cpu_pkg.sv - shared types and helpers for the jelly CPU data-bus path
//
// Purpose : access-size encodings, data-bus FSM states and byte-rotate helpers
//           shared by the memory access encoder and the data-bus controller.
// Ports   : none (package).

package jelly_cpu_pkg;

  // Access size as presented by the MEM stage.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_LR   = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } dbus_state_t;

  // Rotate a word right by whole bytes.
  function automatic logic [31:0] rotr32(input logic [31:0] data, input logic [1:0] shift);
    logic [31:0] r;
    case (shift)
      2'd0:    r = data;
      2'd1:    r = {data[7:0],  data[31:8]};
      2'd2:    r = {data[15:0], data[31:16]};
      default: r = {data[23:0], data[31:24]};
    endcase
    return r;
  endfunction

  // Rotate a word left by whole bytes (inverse of rotr32).
  function automatic logic [31:0] rotl32(input logic [31:0] data, input logic [1:0] shift);
    logic [31:0] r;
    case (shift)
      2'd0:    r = data;
      2'd1:    r = {data[23:0], data[31:24]};
      2'd2:    r = {data[15:0], data[31:16]};
      default: r = {data[7:0],  data[31:8]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jelly_cpu_memenc.sv
// rtl/jelly_cpu_memenc.sv - memory access encoder (lane selects, write data, merge mask)
//
// Purpose : turns endian, low address bits and access size into Wishbone byte
//           selects, lane-aligned write data, the LWL/LWR merge mask and the
//           byte rotation the read path must undo.
// Ports   : endian    in  1   1 = big-endian
//           addr      in  2   byte offset within the word
//           size      in  2   access size (SIZE_*)
//           lr_right  in  1   size LR only: 1 = right variant, 0 = left
//           wdata     in  32  store data, register aligned
//           enc_wdata out 32  store data placed on its byte lanes
//           sel       out 4   byte lane selects
//           mask      out 4   result bytes taken from memory for LWL/LWR
//           shift     out 2   byte rotation between register and bus lanes

module jelly_cpu_memenc
  import jelly_cpu_pkg::*;
#(
  parameter bit USE_INST_LSWLR = 1'b1
) (
  input  logic        endian,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        lr_right,
  input  logic [31:0] wdata,
  output logic [31:0] enc_wdata,
  output logic [3:0]  sel,
  output logic [3:0]  mask,
  output logic [1:0]  shift
);

  // Big-endian lane numbering is the little-endian one mirrored, so every
  // case is expressed on a little-endian equivalent offset.
  logic [1:0] off;

  always_comb begin
    off   = endian ? ~addr : addr;
    sel   = 4'b1111;
    mask  = 4'b1111;
    shift = 2'd0;
    case (size)
      SIZE_BYTE: begin
        shift = off;
        sel   = 4'b0001 << off;
      end
      SIZE_HALF: begin
        shift = {off[1], 1'b0};
        sel   = 4'b0011 << {off[1], 1'b0};
      end
      SIZE_LR: begin
        if (USE_INST_LSWLR) begin
          if (lr_right) begin
            // Bytes from the offset up to the word end fill the low end.
            shift = off;
            mask  = 4'b1111 >> off;
            sel   = 4'b1111 << off;
          end else begin
            // Bytes from the word start up to the offset fill the high end.
            shift = off + 2'd1;
            mask  = 4'b1111 << (2'd3 - off);
            sel   = 4'b1111 >> (2'd3 - off);
          end
        end
      end
      default: begin
        sel = 4'b1111;
      end
    endcase
  end

  // The read path rotates right by shift; stores need the inverse.
  assign enc_wdata = rotl32(wdata, shift);

endmodule

// File: rtl/jelly_cpu_dbus_ctl.sv
// rtl/jelly_cpu_dbus_ctl.sv - single-beat Wishbone data-bus access controller
//
// Purpose : accepts one load/store from the MEM stage, runs one Wishbone
//           classic cycle, stalls the pipeline meanwhile and returns the
//           aligned/extended/merged load result to writeback.
// Ports   : clk, reset_n (async active-low)
//           endian, in_valid, in_we, in_addr, in_wdata, in_size, in_unsigned,
//           in_rt_data                       - request from the MEM stage
//           out_busy, out_valid, out_rdata, out_err - pipeline response
//           wb_adr_o, wb_dat_o, wb_dat_i, wb_we_o, wb_sel_o, wb_stb_o,
//           wb_ack_i                         - Wishbone classic master

module jelly_cpu_dbus_ctl
  import jelly_cpu_pkg::*;
#(
  parameter bit USE_INST_LSWLR = 1'b1,
  parameter int TIMEOUT        = 0,
  parameter int TIMER_WIDTH    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        endian,
  input  logic        in_valid,
  input  logic        in_we,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_rt_data,
  output logic        out_busy,
  output logic        out_valid,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic [29:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT - 1);

  dbus_state_t state;
  dbus_state_t next_state;

  logic [31:0] enc_wdata;
  logic [3:0]  enc_sel;
  logic [3:0]  enc_mask;
  logic [1:0]  enc_shift;

  logic [3:0]  mask_r;
  logic [1:0]  shift_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic [TIMER_WIDTH-1:0] timer;
  logic        timeout_hit;

  logic [31:0] rot;
  logic [31:0] fmt;

  jelly_cpu_memenc #(
    .USE_INST_LSWLR (USE_INST_LSWLR)
  ) u_memenc (
    .endian    (endian),
    .addr      (in_addr[1:0]),
    .size      (in_size),
    .lr_right  (in_unsigned),
    .wdata     (in_wdata),
    .enc_wdata (enc_wdata),
    .sel       (enc_sel),
    .mask      (enc_mask),
    .shift     (enc_shift)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        if (TIMEOUT != 0 && timer == TIMER_LAST) begin
          timeout_hit = 1'b1;
        end
        if (wb_ack_i || timeout_hit) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Strobe and handshakes come straight from the state register, so reset
  // drops the strobe at once and nothing on wb_* depends on in_* directly.
  assign wb_stb_o  = (state == ST_REQ);
  assign out_valid = (state == ST_DONE);
  assign out_busy  = ((state == ST_IDLE) && in_valid) || (state == ST_REQ);

  always_comb begin
    rot = rotr32(wb_dat_i, shift_r);
    fmt = rot;
    case (size_r)
      SIZE_BYTE: fmt = {{24{~unsigned_r & rot[7]}},  rot[7:0]};
      SIZE_HALF: fmt = {{16{~unsigned_r & rot[15]}}, rot[15:0]};
      SIZE_LR: begin
        if (USE_INST_LSWLR) begin
          for (int i = 0; i < 4; i++) begin
            fmt[8*i +: 8] = mask_r[i] ? rot[8*i +: 8] : in_rt_data[8*i +: 8];
          end
        end
      end
      default: fmt = rot;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= '0;
      wb_we_o    <= 1'b0;
      mask_r     <= '0;
      shift_r    <= '0;
      size_r     <= '0;
      unsigned_r <= 1'b0;
      timer      <= '0;
      out_rdata  <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            wb_adr_o   <= in_addr[31:2];
            wb_dat_o   <= enc_wdata;
            wb_sel_o   <= enc_sel;
            wb_we_o    <= in_we;
            mask_r     <= enc_mask;
            shift_r    <= enc_shift;
            size_r     <= in_size;
            unsigned_r <= in_unsigned;
            timer      <= '0;
            out_err    <= 1'b0;
          end
        end
        ST_REQ: begin
          timer <= timer + TIMER_WIDTH'(1);
          if (wb_ack_i) begin
            // Ack beats a simultaneous timeout.
            if (!wb_we_o) begin
              out_rdata <= fmt;
            end
            out_err <= 1'b0;
          end else if (timeout_hit) begin
            out_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
